// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl -- multicycle execute sequencer in front of the combinational ALU.
//
// Accepts one decoded operation at a time (valid/ready), registers the ALU
// control inputs and holds them while the ALU settles (MUL_CYCLES cycles for
// multiply, one cycle otherwise), captures the result for register writeback
// and owns the architectural NZCV flag register.
//
// Optional feature (compile-time macro):
//   ALU_SEQ_COND_EXEC_EN  - evaluate issue_cond against NZCV at acceptance;
//                           failing operations pulse op_skipped. Without it
//                           every legal operation executes and op_skipped = 0.
//
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   issue_valid/ready        decode handshake (ready depends on state only)
//   issue_opcode/s/sr_cont/sr_bit/imm/rd/cond   decoded operation fields
//   alu_opcode/s/sr_cont/sr_bit/imm             registered ALU controls
//   alu_out, alu_n/z/c/v     ALU result and flags
//   wb_valid, wb_rd, wb_data one-cycle writeback strobe, target, data
//   flag_n/z/c/v             architectural flags
//   op_skipped, op_illegal   one-cycle pulses for failed condition / bad opcode

module alu_seq_ctrl #(
    parameter int MUL_CYCLES = 3          // 1..15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        issue_valid,
    output logic        issue_ready,
    input  logic [3:0]  issue_opcode,
    input  logic        issue_s,
    input  logic [2:0]  issue_sr_cont,
    input  logic [4:0]  issue_sr_bit,
    input  logic [15:0] issue_imm,
    input  logic [3:0]  issue_rd,
    input  logic [3:0]  issue_cond,
    output logic [3:0]  alu_opcode,
    output logic        alu_s,
    output logic [2:0]  alu_sr_cont,
    output logic [4:0]  alu_sr_bit,
    output logic [15:0] alu_imm,
    input  logic [31:0] alu_out,
    input  logic        alu_n,
    input  logic        alu_z,
    input  logic        alu_c,
    input  logic        alu_v,
    output logic        wb_valid,
    output logic [3:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        flag_n,
    output logic        flag_z,
    output logic        flag_c,
    output logic        flag_v,
    output logic        op_skipped,
    output logic        op_illegal
);

    localparam logic [3:0] OP_MUL = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0100;
    localparam logic [3:0] OP_CMP = 4'b1011;
    localparam logic [3:0] OP_TST = 4'b1101;

    // EXEC is the first multiply cycle, so MUL only covers the remaining
    // MUL_CYCLES-1 cycles: counter starts at MUL_CYCLES-2 and samples at 0.
    localparam logic [3:0] MUL_LOAD = (MUL_CYCLES > 1) ? 4'(MUL_CYCLES - 2) : 4'd0;

    typedef enum logic [1:0] {IDLE, EXEC, MUL, WB} state_t;

    state_t     state_q, state_d;
    logic [3:0] mul_cnt_q, mul_cnt_d;
    logic [3:0] rd_q;
    logic       no_wb_q;       // CMP/TST: flags only, no register write
    logic       accept;
    logic       sample;
    logic       op_legal;
    logic       is_cmp_tst;
    logic       cond_pass;

    assign op_legal   = (issue_opcode[3] == 1'b0) || (issue_opcode == OP_CMP) ||
                        (issue_opcode == OP_TST);
    assign is_cmp_tst = (issue_opcode == OP_CMP) || (issue_opcode == OP_TST);

`ifdef ALU_SEQ_COND_EXEC_EN
    function automatic logic cond_eval(input logic [3:0] c, input logic n, input logic z,
                                       input logic cf, input logic v);
        logic r;
        case (c)
            4'b0000: r = z;                   // EQ
            4'b0001: r = !z;                  // NE
            4'b0010: r = cf;                  // CS
            4'b0011: r = !cf;                 // CC
            4'b0100: r = n;                   // MI
            4'b0101: r = !n;                  // PL
            4'b0110: r = v;                   // VS
            4'b0111: r = !v;                  // VC
            4'b1000: r = cf && !z;            // HI
            4'b1001: r = !cf || z;            // LS
            4'b1010: r = (n == v);            // GE
            4'b1011: r = (n != v);            // LT
            4'b1100: r = !z && (n == v);      // GT
            4'b1101: r = z || (n != v);       // LE
            4'b1110: r = 1'b1;                // AL
            default: r = 1'b0;                // NV
        endcase
        return r;
    endfunction

    assign cond_pass = cond_eval(issue_cond, flag_n, flag_z, flag_c, flag_v);
`else
    logic unused_cond;
    assign unused_cond = ^issue_cond;
    assign cond_pass   = 1'b1;
    assign op_skipped  = 1'b0;
`endif

    assign issue_ready = (state_q == IDLE);

    // Next-state and sequencing strobes
    always_comb begin
        state_d   = state_q;
        mul_cnt_d = mul_cnt_q;
        accept    = 1'b0;
        sample    = 1'b0;
        case (state_q)
            IDLE: begin
                if (issue_valid) begin
                    accept = 1'b1;
                    if (op_legal && cond_pass)
                        state_d = EXEC;
                end
            end
            EXEC: begin
                if ((alu_opcode == OP_MUL) && (MUL_CYCLES > 1)) begin
                    mul_cnt_d = MUL_LOAD;
                    state_d   = MUL;
                end else begin
                    sample  = 1'b1;
                    state_d = WB;
                end
            end
            MUL: begin
                if (mul_cnt_q == 4'd0) begin
                    sample  = 1'b1;
                    state_d = WB;
                end else begin
                    mul_cnt_d = mul_cnt_q - 4'd1;
                end
            end
            WB:      state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            mul_cnt_q   <= 4'd0;
            rd_q        <= 4'd0;
            no_wb_q     <= 1'b0;
            alu_opcode  <= 4'd0;
            alu_s       <= 1'b0;
            alu_sr_cont <= 3'd0;
            alu_sr_bit  <= 5'd0;
            alu_imm     <= 16'd0;
            wb_valid    <= 1'b0;
            wb_rd       <= 4'd0;
            wb_data     <= 32'd0;
            flag_n      <= 1'b0;
            flag_z      <= 1'b0;
            flag_c      <= 1'b0;
            flag_v      <= 1'b0;
            op_illegal  <= 1'b0;
        end else begin
            state_q    <= state_d;
            mul_cnt_q  <= mul_cnt_d;
            wb_valid   <= 1'b0;
            op_illegal <= 1'b0;

            if (accept) begin
                // CMP/TST reuse SUB/AND with forced flag update
                alu_opcode  <= (issue_opcode == OP_CMP) ? OP_SUB :
                               (issue_opcode == OP_TST) ? OP_AND : issue_opcode;
                alu_s       <= issue_s || is_cmp_tst;
                alu_sr_cont <= issue_sr_cont;
                alu_sr_bit  <= issue_sr_bit;
                alu_imm     <= issue_imm;
                rd_q        <= issue_rd;
                no_wb_q     <= is_cmp_tst;
                op_illegal  <= !op_legal;
            end

            if (sample) begin
                if (!no_wb_q) begin
                    wb_valid <= 1'b1;
                    wb_rd    <= rd_q;
                    wb_data  <= alu_out;
                end
                if (alu_s) begin
                    flag_n <= alu_n;
                    flag_z <= alu_z;
                    flag_c <= alu_c;
                    flag_v <= alu_v;
                end
            end
        end
    end

`ifdef ALU_SEQ_COND_EXEC_EN
    // Illegal opcodes report as illegal, never as skipped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            op_skipped <= 1'b0;
        else
            op_skipped <= accept && op_legal && !cond_pass;
    end
`endif

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb_alu_seq_ctrl -- directed-vector bench for alu_seq_ctrl (MUL_CYCLES = 3).
// Inputs change and outputs are sampled on the falling edge; "cycle N" is the
// cycle after the Nth rising edge counted from the acceptance edge (cycle 0).

module tb_alu_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        issue_valid = 1'b0;
    logic        issue_ready;
    logic [3:0]  issue_opcode = 4'd0;
    logic        issue_s = 1'b0;
    logic [2:0]  issue_sr_cont = 3'd0;
    logic [4:0]  issue_sr_bit = 5'd0;
    logic [15:0] issue_imm = 16'd0;
    logic [3:0]  issue_rd = 4'd0;
    logic [3:0]  issue_cond = 4'b1110;
    logic [3:0]  alu_opcode;
    logic        alu_s;
    logic [2:0]  alu_sr_cont;
    logic [4:0]  alu_sr_bit;
    logic [15:0] alu_imm;
    logic [31:0] alu_out = 32'd0;
    logic        alu_n = 1'b0, alu_z = 1'b0, alu_c = 1'b0, alu_v = 1'b0;
    logic        wb_valid;
    logic [3:0]  wb_rd;
    logic [31:0] wb_data;
    logic        flag_n, flag_z, flag_c, flag_v;
    logic        op_skipped, op_illegal;
    logic [3:0]  nzcv;

    assign nzcv = {flag_n, flag_z, flag_c, flag_v};

    alu_seq_ctrl #(.MUL_CYCLES(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_opcode(issue_opcode), .issue_s(issue_s),
        .issue_sr_cont(issue_sr_cont), .issue_sr_bit(issue_sr_bit),
        .issue_imm(issue_imm), .issue_rd(issue_rd), .issue_cond(issue_cond),
        .alu_opcode(alu_opcode), .alu_s(alu_s), .alu_sr_cont(alu_sr_cont),
        .alu_sr_bit(alu_sr_bit), .alu_imm(alu_imm),
        .alu_out(alu_out), .alu_n(alu_n), .alu_z(alu_z), .alu_c(alu_c), .alu_v(alu_v),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .flag_n(flag_n), .flag_z(flag_z), .flag_c(flag_c), .flag_v(flag_v),
        .op_skipped(op_skipped), .op_illegal(op_illegal)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic present(input logic [3:0] op, input logic s, input logic [3:0] rd,
                           input logic [3:0] cond);
        issue_valid   = 1'b1;
        issue_opcode  = op;
        issue_s       = s;
        issue_rd      = rd;
        issue_cond    = cond;
        issue_sr_cont = 3'd5;
        issue_sr_bit  = 5'd7;
        issue_imm     = 16'h1234;
    endtask

    task automatic alu_set(input logic [31:0] o, input logic [3:0] f);
        alu_out = o;
        {alu_n, alu_z, alu_c, alu_v} = f;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int wb_seen;

        // ---- reset state
        repeat (2) @(negedge clk);
        chk("rst_ready", issue_ready, 1);
        chk("rst_opcode", alu_opcode, 0);
        chk("rst_alu_s", alu_s, 0);
        chk("rst_imm", alu_imm, 0);
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_wb_data", wb_data, 0);
        chk("rst_nzcv", nzcv, 0);
        chk("rst_pulses", {op_skipped, op_illegal}, 0);
        rst_n = 1'b1;

        // ---- ADD, S=1, rd=3, result 5, ALU C=1 -> NZCV 0010
        alu_set(32'h5, 4'b0010);
        present(4'b0000, 1'b1, 4'd3, 4'b1110);
        step();                                   // cycle 1
        issue_valid = 1'b0;
        chk("add_c1_ready", issue_ready, 0);
        chk("add_c1_wb", wb_valid, 0);
        chk("add_c1_imm", alu_imm, 32'h1234);
        chk("add_c1_srbit", alu_sr_bit, 7);
        step();                                   // cycle 2
        chk("add_c2_wb", wb_valid, 1);
        chk("add_c2_rd", wb_rd, 3);
        chk("add_c2_data", wb_data, 5);
        chk("add_c2_nzcv", nzcv, 4'b0010);
        step();                                   // cycle 3
        chk("add_c3_ready", issue_ready, 1);
        chk("add_c3_wb", wb_valid, 0);

        // ---- MUL, S=0, rd=5: wb in cycle 4, flags untouched
        alu_set(32'h30, 4'b1111);
        present(4'b0010, 1'b0, 4'd5, 4'b1110);
        step();
        issue_valid = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            chk($sformatf("mul_c%0d_ready", c), issue_ready, 0);
            chk($sformatf("mul_c%0d_wb", c), wb_valid, 0);
            chk($sformatf("mul_c%0d_op", c), alu_opcode, 4'b0010);
            step();
        end
        chk("mul_c4_wb", wb_valid, 1);
        chk("mul_c4_data", wb_data, 32'h30);
        chk("mul_c4_rd", wb_rd, 5);
        chk("mul_c4_op", alu_opcode, 4'b0010);
        chk("mul_c4_nzcv", nzcv, 4'b0010);
        step();
        chk("mul_c5_ready", issue_ready, 1);

        // ---- CMP, ALU Z=1 -> remap to 0001, S forced, no wb, NZCV 0100
        alu_set(32'h0, 4'b0100);
        present(4'b1011, 1'b0, 4'd7, 4'b1110);
        step();
        issue_valid = 1'b0;
        chk("cmp_op", alu_opcode, 4'b0001);
        chk("cmp_s", alu_s, 1);
        wb_seen = 0;
        for (int c = 1; c <= 3; c++) begin
            wb_seen += int'(wb_valid);
            if (c < 3) step();
        end
        chk("cmp_no_wb", wb_seen, 0);
        chk("cmp_nzcv", nzcv, 4'b0100);
        step();
        chk("cmp_ready", issue_ready, 1);

        // ---- ADD cond=EQ executes (Z=1)
        alu_set(32'h9, 4'b0000);
        present(4'b0000, 1'b0, 4'd2, 4'b0000);
        step();
        issue_valid = 1'b0;
        chk("eq_skip", op_skipped, 0);
        step();
        chk("eq_wb", wb_valid, 1);
        chk("eq_data", wb_data, 9);
        step();

        // ---- ADD cond=NE: skipped when conditional execution is built in
        alu_set(32'hB, 4'b0000);
        present(4'b0000, 1'b0, 4'd2, 4'b0001);
        step();                                   // cycle 1
        issue_valid = 1'b0;
`ifdef ALU_SEQ_COND_EXEC_EN
        chk("ne_skip_pulse", op_skipped, 1);
        chk("ne_ready", issue_ready, 1);
        step();                                   // cycle 2
        chk("ne_skip_end", op_skipped, 0);
        chk("ne_no_wb", wb_valid, 0);
        chk("ne_data_kept", wb_data, 9);
`else
        chk("ne_skip_tied", op_skipped, 0);
        step();
        chk("ne_wb", wb_valid, 1);
        chk("ne_data", wb_data, 32'hB);
        step();
`endif
        chk("ne_nzcv", nzcv, 4'b0100);

        // ---- illegal 1000, then SUB accepted in cycle 1 -> NZCV 1010
        present(4'b1000, 1'b1, 4'd9, 4'b1110);
        step();                                   // cycle 1
        chk("ill_pulse", op_illegal, 1);
        chk("ill_ready", issue_ready, 1);
        chk("ill_wb", wb_valid, 0);
        chk("ill_nzcv", nzcv, 4'b0100);
        alu_set(32'hFFFF_FFFE, 4'b1010);
        present(4'b0001, 1'b1, 4'd4, 4'b1110);
        step();                                   // SUB in EXEC
        issue_valid = 1'b0;
        chk("ill_pulse_end", op_illegal, 0);
        chk("b2b_accepted", issue_ready, 0);
        chk("b2b_c1_wb", wb_valid, 0);
        step();
        chk("sub_wb", wb_valid, 1);
        chk("sub_rd", wb_rd, 4);
        chk("sub_data", wb_data, 32'hFFFF_FFFE);
        chk("sub_nzcv", nzcv, 4'b1010);
        step();

        // ---- ORR S=0: writes back, flags stay 1010
        alu_set(32'hA5A5, 4'b0101);
        present(4'b0011, 1'b0, 4'd6, 4'b1110);
        step();
        issue_valid = 1'b0;
        step();
        chk("orr_wb", wb_valid, 1);
        chk("orr_data", wb_data, 32'hA5A5);
        chk("orr_nzcv", nzcv, 4'b1010);
        step();

        // ---- TST -> remap 0100, S forced, no wb, NZCV from ALU (0100)
        alu_set(32'h77, 4'b0100);
        present(4'b1101, 1'b0, 4'd8, 4'b1110);
        step();
        issue_valid = 1'b0;
        chk("tst_op", alu_opcode, 4'b0100);
        chk("tst_s", alu_s, 1);
        step();
        chk("tst_no_wb", wb_valid, 0);
        chk("tst_nzcv", nzcv, 4'b0100);
        chk("tst_data_kept", wb_data, 32'hA5A5);
        step();

        // ---- reset during cycle 2 of a MUL
        alu_set(32'h1111, 4'b1111);
        present(4'b0010, 1'b1, 4'd1, 4'b1110);
        step();                                   // cycle 1
        issue_valid = 1'b0;
        step();                                   // cycle 2
        rst_n = 1'b0;
        #1;
        chk("mrst_ready", issue_ready, 1);
        chk("mrst_opcode", alu_opcode, 0);
        chk("mrst_alu_s", alu_s, 0);
        chk("mrst_nzcv", nzcv, 0);
        chk("mrst_wb_data", wb_data, 0);
        chk("mrst_wb_rd", wb_rd, 0);
        step();
        rst_n = 1'b1;
        wb_seen = 0;
        for (int c = 0; c < 6; c++) begin
            wb_seen += int'(wb_valid);
            step();
        end
        chk("mrst_no_wb", wb_seen, 0);
        chk("mrst_nzcv_after", nzcv, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
